// File: rtl/decode_stage.sv
// Registered RV32I/RV64I ID-stage decoder with valid/ready handshake, flush,
// load-use hazard stall and a saturating stall counter.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_load_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic             rd_write,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_write;
    logic            illegal;
  } dec_t;

  dec_t             dec_d, dec_q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_q;
  logic [31:0]      imm32;
  logic             has_f3, wr_fmt;
  logic             hazard, accept, fire;

  always_comb begin
    dec_d        = '0;
    imm32        = '0;
    has_f3       = 1'b0;
    wr_fmt       = 1'b0;
    dec_d.opcode = in_instr[6:0];
    unique case (in_instr[6:0])
      OpR: begin
        has_f3         = 1'b1;
        wr_fmt         = 1'b1;
        dec_d.func7    = in_instr[31:25];
        dec_d.rs1_used = 1'b1;
        dec_d.rs2_used = 1'b1;
      end
      OpImm, OpLoad, OpJalr: begin
        has_f3         = 1'b1;
        wr_fmt         = 1'b1;
        dec_d.rs1_used = 1'b1;
        imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        has_f3         = 1'b1;
        dec_d.rs1_used = 1'b1;
        dec_d.rs2_used = 1'b1;
        imm32          = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpBr: begin
        has_f3         = 1'b1;
        dec_d.rs1_used = 1'b1;
        dec_d.rs2_used = 1'b1;
        imm32          = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        wr_fmt = 1'b1;
        imm32  = {in_instr[31:12], 12'b0};
      end
      OpJal: begin
        wr_fmt = 1'b1;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
      end
      default: dec_d.illegal = 1'b1;
    endcase
    // Unused fields are forced to zero so downstream never sees stale bits.
    dec_d.imm      = XLEN'($signed(imm32));
    dec_d.func3    = has_f3 ? in_instr[14:12] : 3'd0;
    dec_d.rs1      = dec_d.rs1_used ? in_instr[19:15] : 5'd0;
    dec_d.rs2      = dec_d.rs2_used ? in_instr[24:20] : 5'd0;
    dec_d.rd_write = wr_fmt & (in_instr[11:7] != 5'd0);
    dec_d.rd       = dec_d.rd_write ? in_instr[11:7] : 5'd0;
  end

  assign hazard = valid_q & ex_load_valid & (ex_load_rd != 5'd0) &
                  ((dec_q.rs1_used & (dec_q.rs1 == ex_load_rd)) |
                   (dec_q.rs2_used & (dec_q.rs2 == ex_load_rd)));

  assign out_valid = valid_q & ~hazard;
  assign in_ready  = ~valid_q | (out_ready & ~hazard);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        dec_q   <= dec_d;
        pc_q    <= in_pc;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
      if (hazard && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign out_pc      = pc_q;
  assign opcode      = dec_q.opcode;
  assign func3       = dec_q.func3;
  assign func7       = dec_q.func7;
  assign rs1         = dec_q.rs1;
  assign rs2         = dec_q.rs2;
  assign rd          = dec_q.rd;
  assign imm         = dec_q.imm;
  assign rs1_used    = dec_q.rs1_used;
  assign rs2_used    = dec_q.rs2_used;
  assign rd_write    = dec_q.rd_write;
  assign illegal     = dec_q.illegal;
  assign stall_count = stall_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered ID-stage decoder for the five-stage RV32I/RV64I pipeline. Sits between the IF/ID and ID/EX boundaries.
- Extracts all instruction fields and builds the sign-extended immediate for every base format.
- Produces register-use and write-enable flags and an illegal flag. Unused fields are driven to zero, never held.
- Adds a valid/ready handshake, flush, load-use hazard stall and a saturating stall counter.

Parameters:
- XLEN, 32, datapath width for pc and immediate (32 or 64).
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  IF/ID beat valid
- in_ready  output  1  stage can accept a beat this cycle
- in_instr  input  32  raw instruction
- in_pc  input  XLEN  pc of in_instr
- flush  input  1  synchronous kill of held and incoming beat
- ex_load_valid  input  1  EX stage currently holds a load
- ex_load_rd  input  5  destination of that load
- out_valid  output  1  decoded beat valid toward EX (masked by hazard)
- out_ready  input  1  EX accepts
- out_pc  output  XLEN  registered pc
- opcode  output  7  instr[6:0]
- func3  output  3  instr[14:12] if format has it, else 0
- func7  output  7  instr[31:25] for R-type only, else 0
- rs1  output  5  instr[19:15] if used, else 0
- rs2  output  5  instr[24:20] if used, else 0
- rd  output  5  instr[11:7] if written, else 0
- imm  output  XLEN  sign-extended immediate, 0 for R-type/illegal
- rs1_used  output  1  R, I, load, S, B, JALR
- rs2_used  output  1  R, S, B
- rd_write  output  1  R, I, load, LUI, AUIPC, JAL, JALR, and rd!=0
- illegal  output  1  instr[1:0]!=2'b11 or opcode outside the nine RV base opcodes
- stall_count  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=1 at edge): valid_q=0, all registered outputs 0, stall_count=0. Reset overrides flush and any handshake. Reset mid-handshake drops the held beat.
- Opcodes: R 0110011, I 0010011, load 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Immediates, sign-extended from instr[31] to XLEN:
  - I/load/JALR: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal beat: opcode still reported. All other fields, flags and imm are 0. illegal=1. Beat still flows downstream.
- Decode is combinational on in_instr and captured on accept. Latency is 1 cycle from accepted input to out_valid.
- hazard = valid_q & ex_load_valid & (ex_load_rd!=0) & ((rs1_used & rs1==ex_load_rd) | (rs2_used & rs2==ex_load_rd)).
- out_valid = valid_q & ~hazard.
- in_ready = ~valid_q | (out_ready & ~hazard).
- Accept when in_valid & in_ready: register loads the new beat. A simultaneous out fire plus accept is a seamless back-to-back transfer.
- Out fire without accept: valid_q goes to 0.
- Held state: registered outputs are stable while valid_q=1 and the beat has not fired, including under backpressure and hazard.
- flush=1: valid_q goes to 0 at the next edge. An incoming beat in the same cycle is discarded. Output fields may retain stale values. flush takes priority over accept.
- stall_count increments by 1 on each cycle with hazard=1 and saturates at all-ones. It is cleared only by rst.

Test Plan:
- addi x5,x1,-1 = 0xFFF08293, out_ready=1:
  - next cycle out_valid=1, opcode=0x13, rd=5, rs1=1, rs2=0, func3=0, func7=0, imm=0xFFFFFFFF.
  - rs1_used=1, rs2_used=0, rd_write=1.
- sw x2,8(x3) = 0x0021A423 then beq x0,x0,-4 = 0xFE000EE3, back-to-back:
  - sw: rs1=3, rs2=2, imm=8, rd=0, rd_write=0.
  - beq: imm=0xFFFFFFFC, func3=0.
  - in_ready stays 1, no bubble.
- Load-use: hold add x6,x5,x7 = 0x00728333 with ex_load_valid=1, ex_load_rd=5 for one cycle:
  - out_valid=0 and in_ready=0 that cycle, stall_count=1.
  - ex_load_valid=0 next cycle: out_valid=1, same fields.
  - Repeat with ex_load_rd=0: no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and a new instruction:
  - in_ready=0 and outputs unchanged.
  - out_ready=1: old beat fires and new beat is captured in the same cycle.
- Flush/reset:
  - flush=1 with in_valid=1 while holding a beat: out_valid=0 next cycle.
  - rst=1 during backpressure: all outputs 0 and stall_count=0 next cycle.
- Illegal: 0x00000000 gives illegal=1 and rd_write=rs1_used=rs2_used=0.
  - 0x0000007F (bad opcode, low bits 11) gives illegal=1.
  - With CNT_W=2, 5 hazard cycles give stall_count=3.
